dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Sequences and shares the word-wide data memory between two requesters:
//   - core: pipeline MEM stage
//   - ext: program loader / debug port
//  Round-robin arbitration; byte/halfword stores done as read-modify-write (memory writes whole words only).
//  Sub-word loads extracted by byte offset and sign/zero-extended per funct3.
//  Sits between the core/loader and the data memory; all memory traffic passes through it.
// PARAMETERS
//  DM_ADDRESS  9   byte-address width of data memory space
//  DATA_W      32  data word width (only 32 supported)
// PORTS
//  clk           in   1           single clock, all state on rising edge
//  reset         in   1           synchronous, active-high
//  core_req      in   1           core access request, held until core_gnt
//  core_we       in   1           1=store, 0=load
//  core_funct3   in   3           RV32I load/store funct3
//  core_addr     in   DM_ADDRESS  byte address
//  core_wdata    in   DATA_W      store data (low bytes used for SB/SH)
//  core_gnt      out  1           request accepted this cycle
//  core_rvalid   out  1           1-cycle completion pulse (loads and stores)
//  core_rdata    out  DATA_W      load result, valid with core_rvalid
//  core_err      out  1           with core_rvalid: misaligned/illegal, no memory effect
//  ext_*         --   --          identical set for the ext requester (req, we, funct3, addr, wdata, gnt, rvalid, rdata, err)
//  mem_addr      out  32          word address {0, addr[DM_ADDRESS-1:2], 2'b00}
//  mem_wdata     out  DATA_W      full word to write
//  mem_wr        out  4           4'b1111 in WR state, else 4'b0000
//  mem_rdata     in   DATA_W      memory read data, valid 1 cycle after mem_addr
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=EXT (core wins first tie); all gnt/rvalid/err=0, rdata=0, mem_wr=0.
//  States:
//   IDLE  -> gnt combinational when state==IDLE; one requester only.
//            Both requesting: grant the one not in last_grant. Capture we/funct3/addr/wdata; update last_grant.
//            Next: illegal ? RESP : (SW ? WR : RD).
//   RD    -> drive mem_addr, mem_wr=0.
//            Next: load ? RESP : MERGE.
//   MERGE -> latch mem_rdata into merge_q with SB/SH lane replaced by wdata[7:0]/[15:0] at addr[1:0]/addr[1].
//            Next: WR.
//   WR    -> mem_wr=4'b1111, mem_wdata = merge_q (SB/SH) or wdata (SW).
//            Next: RESP.
//   RESP  -> rvalid=1 to owner only, rdata/err registered.
//            Next: IDLE (no grant in RESP).
//  Latency grant->rvalid:
//   - load: 2 cycles (rdata formatted from mem_rdata in cycle after RD)
//   - SW: 2 cycles; SB/SH: 4 cycles; illegal: 1 cycle
//  Load formatting (byte lane = addr[1:0]):
//   - LB: sign-extend; LBU: zero-extend
//   - LH/LHU: lane addr[1]*16, sign/zero-extend
//   - LW: whole word
//  Illegal (err=1, rdata=0, mem_wr never asserted):
//   - LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0
//   - funct3 011,110,111; store funct3[2]=1
//  Non-owner rvalid/err stay 0. A request dropped before gnt is a protocol violation (undefined).
//  Reset asserted in any state: next cycle IDLE; mem_wr forced 0 while reset=1; pending access dropped, no rvalid.
//  Addr bits above DM_ADDRESS-1 of mem_addr are 0; no wrap logic needed.
// STRUCTURE
//  Package dmem_pkg:
//   - funct3 localparams (F3_LB..F3_LHU, F3_SB..F3_SW)
//   - state enum {IDLE,RD,MERGE,WR,RESP}
//   - owner enum {CORE,EXT}
//  Sub-module dmem_lane_fmt (combinational):
//   - load extract/extend
//   - store merge
//   - legality check
//  Used once per access path.
// TESTING
//  1 mem[0x10]=0x8899AABB; core LB @0x11 -> rvalid 2 cyc after gnt, rdata=0xFFFFFFAA; LBU @0x11 -> 0x000000AA.
//  2 mem[0x20]=0x11223344; core SB @0x22 wdata=0x55 -> single WR, mem[0x20]=0x11553344; rvalid 4 cyc after gnt, err=0.
//  3 core and ext req same cycle from reset -> core granted first, ext granted on next IDLE; repeat -> alternates.
//  4 core LW @0x06 -> err=1, rdata=0, rvalid 1 cyc after gnt, mem_wr never 1; SH @0x03 -> err, memory unchanged.
//  5 mem[0x30]=0x0000F00D; LH @0x30 -> 0xFFFFF00D; LHU -> 0x0000F00D; SW 0xDEADBEEF then LW -> 0xDEADBEEF.
//  6 reset pulsed during WR of SB -> mem_wr=0 that cycle, no rvalid, state IDLE next, new req granted immediately.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared funct3 encodings and state/owner types for the data-memory port arbiter.
package dmem_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;
  typedef enum logic {CORE, EXT} owner_t;
endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane handling for one access: load extract/extend, store merge into
// the word read back from memory, and alignment/funct3 legality.
module dmem_lane_fmt
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_lane,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merge,
  output logic              o_illegal
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_load    = '0;
    o_merge   = i_rdata;
    o_illegal = 1'b0;
    if (i_we) begin
      case (i_funct3)
        F3_SB: o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
        F3_SH: begin
          o_illegal = i_lane[0];
          if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
          else           o_merge[15:0]  = i_wdata[15:0];
        end
        F3_SW: begin
          o_illegal = |i_lane;
          o_merge   = i_wdata;
        end
        default: o_illegal = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        F3_LB:  o_load = {{24{w_byte[7]}}, w_byte};
        F3_LBU: o_load = {24'h000000, w_byte};
        F3_LH: begin
          o_illegal = i_lane[0];
          o_load    = {{16{w_half[15]}}, w_half};
        end
        F3_LHU: begin
          o_illegal = i_lane[0];
          o_load    = {16'h0000, w_half};
        end
        F3_LW: begin
          o_illegal = |i_lane;
          o_load    = i_rdata;
        end
        default: o_illegal = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin sharing of a word-wide data memory between the core MEM stage and
// the loader/debug port; sub-word stores are done as read-modify-write.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [2:0]            i_core_funct3,
  input  logic [DM_ADDRESS-1:0] i_core_addr,
  input  logic [DATA_W-1:0]     i_core_wdata,
  output logic                  o_core_gnt,
  output logic                  o_core_rvalid,
  output logic [DATA_W-1:0]     o_core_rdata,
  output logic                  o_core_err,
  input  logic                  i_ext_req,
  input  logic                  i_ext_we,
  input  logic [2:0]            i_ext_funct3,
  input  logic [DM_ADDRESS-1:0] i_ext_addr,
  input  logic [DATA_W-1:0]     i_ext_wdata,
  output logic                  o_ext_gnt,
  output logic                  o_ext_rvalid,
  output logic [DATA_W-1:0]     o_ext_rdata,
  output logic                  o_ext_err,
  output logic [31:0]           o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [3:0]            o_mem_wr,
  input  logic [DATA_W-1:0]     i_mem_rdata
);
  state_t                r_state, w_state_next;
  owner_t                r_last, r_owner;
  logic                  r_we, r_err;
  logic [2:0]            r_funct3;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata, r_merge;

  logic                  w_gnt, w_pick_core, w_resp;
  logic                  w_sel_we, w_fmt_we, w_illegal;
  logic [2:0]            w_sel_funct3, w_fmt_funct3;
  logic [DM_ADDRESS-1:0] w_sel_addr;
  logic [1:0]            w_fmt_lane;
  logic [DATA_W-1:0]     w_sel_wdata, w_fmt_wdata, w_load, w_merge, w_rdata;

  // Core wins a tie unless it took the previous grant.
  assign w_pick_core = i_core_req && (!i_ext_req || (r_last == EXT));
  assign w_gnt       = (r_state == IDLE) && !i_reset && (i_core_req || i_ext_req);
  assign o_core_gnt  = w_gnt && w_pick_core;
  assign o_ext_gnt   = w_gnt && !w_pick_core;

  assign w_sel_we     = w_pick_core ? i_core_we     : i_ext_we;
  assign w_sel_funct3 = w_pick_core ? i_core_funct3 : i_ext_funct3;
  assign w_sel_addr   = w_pick_core ? i_core_addr   : i_ext_addr;
  assign w_sel_wdata  = w_pick_core ? i_core_wdata  : i_ext_wdata;

  // In IDLE the formatter judges the incoming request; afterwards it serves the captured one.
  assign w_fmt_we     = (r_state == IDLE) ? w_sel_we        : r_we;
  assign w_fmt_funct3 = (r_state == IDLE) ? w_sel_funct3    : r_funct3;
  assign w_fmt_lane   = (r_state == IDLE) ? w_sel_addr[1:0] : r_addr[1:0];
  assign w_fmt_wdata  = (r_state == IDLE) ? w_sel_wdata     : r_wdata;

  dmem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
    .i_we      (w_fmt_we),
    .i_funct3  (w_fmt_funct3),
    .i_lane    (w_fmt_lane),
    .i_rdata   (i_mem_rdata),
    .i_wdata   (w_fmt_wdata),
    .o_load    (w_load),
    .o_merge   (w_merge),
    .o_illegal (w_illegal)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt) begin
          if (w_illegal)                              w_state_next = RESP;
          else if (w_sel_we && w_sel_funct3 == F3_SW) w_state_next = WR;
          else                                        w_state_next = RD;
        end
      end
      RD:      w_state_next = r_we ? MERGE : RESP;
      MERGE:   w_state_next = WR;
      WR:      w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_last   <= EXT;
      r_owner  <= CORE;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merge  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_gnt) begin
        r_last   <= w_pick_core ? CORE : EXT;
        r_owner  <= w_pick_core ? CORE : EXT;
        r_we     <= w_sel_we;
        r_funct3 <= w_sel_funct3;
        r_addr   <= w_sel_addr;
        r_wdata  <= w_sel_wdata;
        r_err    <= w_illegal;
      end
      if (r_state == MERGE) r_merge <= w_merge;
    end
  end

  assign w_resp        = (r_state == RESP) && !i_reset;
  assign w_rdata       = (w_resp && !r_we && !r_err) ? w_load : '0;
  assign o_core_rvalid = w_resp && (r_owner == CORE);
  assign o_ext_rvalid  = w_resp && (r_owner == EXT);
  assign o_core_rdata  = o_core_rvalid ? w_rdata : '0;
  assign o_ext_rdata   = o_ext_rvalid  ? w_rdata : '0;
  assign o_core_err    = o_core_rvalid && r_err;
  assign o_ext_err     = o_ext_rvalid  && r_err;

  assign o_mem_addr  = {{(32-DM_ADDRESS){1'b0}}, r_addr[DM_ADDRESS-1:2], 2'b00};
  assign o_mem_wdata = (r_funct3 == F3_SW) ? r_wdata : r_merge;
  assign o_mem_wr    = ((r_state == WR) && !i_reset) ? 4'b1111 : 4'b0000;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized
// accesses scored against a byte-level reference memory model.
module tb_dmem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [2:0]  core_f3 = '0;
  logic [8:0]  core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        core_gnt, core_rvalid, core_err;
  logic [31:0] core_rdata;
  logic        ext_req = 1'b0, ext_we = 1'b0;
  logic [2:0]  ext_f3 = '0;
  logic [8:0]  ext_addr = '0;
  logic [31:0] ext_wdata = '0;
  logic        ext_gnt, ext_rvalid, ext_err;
  logic [31:0] ext_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wr;

  logic [31:0] mem     [0:127];
  logic [31:0] ref_mem [0:127];
  int wr_count = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_core_req(core_req), .i_core_we(core_we), .i_core_funct3(core_f3),
    .i_core_addr(core_addr), .i_core_wdata(core_wdata),
    .o_core_gnt(core_gnt), .o_core_rvalid(core_rvalid), .o_core_rdata(core_rdata), .o_core_err(core_err),
    .i_ext_req(ext_req), .i_ext_we(ext_we), .i_ext_funct3(ext_f3),
    .i_ext_addr(ext_addr), .i_ext_wdata(ext_wdata),
    .o_ext_gnt(ext_gnt), .o_ext_rvalid(ext_rvalid), .o_ext_rdata(ext_rdata), .o_ext_err(ext_err),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wr(mem_wr), .i_mem_rdata(mem_rdata)
  );

  // Synchronous-read word memory behind the arbiter.
  always @(posedge clk) begin
    if (mem_wr == 4'hF) begin
      mem[mem_addr[8:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
    mem_rdata <= mem[mem_addr[8:2]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx] <= v;
    ref_mem[idx] = v;
  endtask

  // Reference model: RV32I load/store semantics on a byte-addressed memory.
  task automatic ref_exec(input bit we, input logic [2:0] f3, input logic [8:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output bit er,
                          output int lat, output int nwr);
    int idx, sh, sh16;
    bit legal;
    logic [31:0] w, b, h, mask;
    idx  = int'(addr) / 4;
    sh   = 8 * (int'(addr) % 4);
    sh16 = 16 * ((int'(addr) / 2) % 2);
    w    = ref_mem[idx];
    if (we) legal = (f3 == 0) || (f3 == 1 && addr % 2 == 0) || (f3 == 2 && addr % 4 == 0);
    else    legal = (f3 == 0 || f3 == 4) || ((f3 == 1 || f3 == 5) && addr % 2 == 0) ||
                    (f3 == 2 && addr % 4 == 0);
    rd = '0; er = 1'b0; nwr = 0;
    if (!legal) begin
      er = 1'b1; lat = 1;
    end else if (!we) begin
      lat = 2;
      b = (w >> sh) & 32'hFF;
      h = (w >> sh16) & 32'hFFFF;
      case (f3)
        3'd0: rd = (b >= 128) ? b + 32'hFFFFFF00 : b;
        3'd4: rd = b;
        3'd1: rd = (h >= 32768) ? h + 32'hFFFF0000 : h;
        3'd5: rd = h;
        default: rd = w;
      endcase
    end else begin
      nwr = 1;
      lat = (f3 == 2) ? 2 : 4;
      if (f3 == 2) ref_mem[idx] = wd;
      else if (f3 == 0) begin
        mask = 32'hFF << sh;
        ref_mem[idx] = (w & ~mask) | ((wd & 32'hFF) << sh);
      end else begin
        mask = 32'hFFFF << sh16;
        ref_mem[idx] = (w & ~mask) | ((wd & 32'hFFFF) << sh16);
      end
    end
  endtask

  // Issue one access on a single port; lat counts cycles from grant to rvalid (-1 on timeout).
  task automatic do_access(input bit ext, input bit we, input logic [2:0] f3, input logic [8:0] addr,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd,
                           output bit er, output int nwr, output bit stray);
    int snap, t;
    bit got;
    lat = -1; rd = '0; er = 1'b0; nwr = 0; stray = 1'b0;
    @(posedge clk); #1;
    snap = wr_count;
    if (ext) begin ext_req = 1; ext_we = we; ext_f3 = f3; ext_addr = addr; ext_wdata = wd; end
    else begin core_req = 1; core_we = we; core_f3 = f3; core_addr = addr; core_wdata = wd; end
    got = 0; t = 0;
    while (!got && t < 16) begin
      @(negedge clk); t++;
      if ((ext ? ext_gnt : core_gnt) === 1'b1) got = 1;
    end
    @(posedge clk); #1;
    core_req = 0; ext_req = 0;
    if (!got) return;
    got = 0; t = 1;
    while (!got && t < 16) begin
      @(negedge clk); t++;
      if ((ext ? (core_rvalid | core_err) : (ext_rvalid | ext_err)) !== 1'b0) stray = 1'b1;
      if ((ext ? ext_rvalid : core_rvalid) === 1'b1) begin
        got = 1; lat = t - 1;
        rd = ext ? ext_rdata : core_rdata;
        er = ext ? ext_err : core_err;
      end
    end
    nwr = wr_count - snap;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({core_gnt, ext_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {core_gnt, ext_gnt}); end
    checks++; if ({core_rvalid, ext_rvalid, core_err, ext_err} !== 4'b0000) begin failures++; $display("FAIL reset_rvalid_err got=%b exp=0000", {core_rvalid, ext_rvalid, core_err, ext_err}); end
    checks++; if (core_rdata !== 32'h0 || ext_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0", core_rdata, ext_rdata); end
    checks++; if (mem_wr !== 4'h0) begin failures++; $display("FAIL reset_mem_wr got=%h exp=0", mem_wr); end
    @(posedge clk); #1 reset = 0;
    $display("txn reset released");
  endtask

  task automatic test_arbitration();
    int owners[$];
    int times[$];
    int cyc;
    set_word(0, 32'hA0A0_0001);
    set_word(1, 32'hB0B0_0002);
    @(posedge clk); #1;
    core_req = 1; core_we = 0; core_f3 = 3'b010; core_addr = 9'h000;
    ext_req  = 1; ext_we  = 0; ext_f3  = 3'b010; ext_addr  = 9'h004;
    cyc = 0;
    while (owners.size() < 4 && cyc < 40) begin
      @(negedge clk); cyc++;
      checks++; if (core_gnt && ext_gnt) begin failures++; $display("FAIL arb_double_gnt cycle=%0d got=11 exp=one", cyc); end
      if (core_gnt) begin owners.push_back(0); times.push_back(cyc); $display("txn arb grant core cycle=%0d", cyc); end
      else if (ext_gnt) begin owners.push_back(1); times.push_back(cyc); $display("txn arb grant ext cycle=%0d", cyc); end
      if (core_rvalid) begin checks++; if (core_rdata !== 32'hA0A0_0001) begin failures++; $display("FAIL arb_core_rdata got=%h exp=a0a00001", core_rdata); end end
      if (ext_rvalid)  begin checks++; if (ext_rdata !== 32'hB0B0_0002) begin failures++; $display("FAIL arb_ext_rdata got=%h exp=b0b00002", ext_rdata); end end
    end
    @(posedge clk); #1;
    core_req = 0; ext_req = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (owners.size() != 4) begin
      failures++; $display("FAIL arb_grants got=%0d exp=4", owners.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (owners[i] != i % 2) begin failures++; $display("FAIL arb_order idx=%0d got=%0d exp=%0d", i, owners[i], i % 2); end
        if (i > 0) begin
          checks++; if (times[i] - times[i-1] != 3) begin failures++; $display("FAIL arb_gap idx=%0d got=%0d exp=3", i, times[i] - times[i-1]); end
        end
      end
    end
  endtask

  task automatic test_loads();
    int lat, nwr, mlat, mnwr;
    logic [31:0] rd, mrd;
    bit er, stray, mer;
    logic [31:0] exp_rd [0:5];
    logic [2:0]  f3s    [0:5];
    logic [8:0]  addrs  [0:5];
    bit          wes    [0:5];
    exp_rd = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFFF00D, 32'h0000F00D, 32'h0, 32'hDEADBEEF};
    f3s    = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd2};
    addrs  = '{9'h011, 9'h011, 9'h030, 9'h030, 9'h030, 9'h030};
    wes    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    set_word(9'h010 / 4, 32'h8899AABB);
    set_word(9'h030 / 4, 32'h0000F00D);
    for (int i = 0; i < 6; i++) begin
      ref_exec(wes[i], f3s[i], addrs[i], 32'hDEADBEEF, mrd, mer, mlat, mnwr);
      do_access(1'b0, wes[i], f3s[i], addrs[i], 32'hDEADBEEF, lat, rd, er, nwr, stray);
      $display("txn load_dir %0d we=%0d f3=%0d addr=%h rdata=%h err=%0d lat=%0d", i, wes[i], f3s[i], addrs[i], rd, er, lat);
      checks++; if (rd !== exp_rd[i]) begin failures++; $display("FAIL load_dir_rdata idx=%0d got=%h exp=%h", i, rd, exp_rd[i]); end
      checks++; if (lat != 2) begin failures++; $display("FAIL load_dir_latency idx=%0d got=%0d exp=2", i, lat); end
      checks++; if (er !== 1'b0 || nwr != (wes[i] ? 1 : 0)) begin failures++; $display("FAIL load_dir_err_wr idx=%0d got=%0d/%0d exp=0/%0d", i, er, nwr, wes[i]); end
    end
  endtask

  task automatic test_sub_store();
    int lat, nwr, mlat, mnwr;
    logic [31:0] rd, mrd;
    bit er, stray, mer;
    set_word(9'h020 / 4, 32'h11223344);
    ref_exec(1'b1, 3'd0, 9'h022, 32'h55, mrd, mer, mlat, mnwr);
    do_access(1'b0, 1'b1, 3'd0, 9'h022, 32'h55, lat, rd, er, nwr, stray);
    $display("txn sb addr=022 wdata=55 err=%0d lat=%0d writes=%0d", er, lat, nwr);
    checks++; if (lat != 4) begin failures++; $display("FAIL sb_latency got=%0d exp=4", lat); end
    checks++; if (er !== 1'b0 || nwr != 1) begin failures++; $display("FAIL sb_err_writes got=%0d/%0d exp=0/1", er, nwr); end
    checks++; if (mem[8] !== 32'h11553344) begin failures++; $display("FAIL sb_mem got=%h exp=11553344", mem[8]); end
    ref_exec(1'b1, 3'd1, 9'h022, 32'h1234BEEF, mrd, mer, mlat, mnwr);
    do_access(1'b1, 1'b1, 3'd1, 9'h022, 32'h1234BEEF, lat, rd, er, nwr, stray);
    $display("txn sh ext addr=022 wdata=1234beef err=%0d lat=%0d writes=%0d", er, lat, nwr);
    checks++; if (lat != 4 || nwr != 1) begin failures++; $display("FAIL sh_latency_writes got=%0d/%0d exp=4/1", lat, nwr); end
    checks++; if (mem[8] !== 32'hBEEF3344) begin failures++; $display("FAIL sh_mem got=%h exp=beef3344", mem[8]); end
    checks++; if (stray !== 1'b0) begin failures++; $display("FAIL sh_stray got=1 exp=0"); end
  endtask

  task automatic test_illegal();
    int lat, nwr;
    logic [31:0] rd;
    bit er, stray;
    bit          exts  [0:3];
    bit          wes   [0:3];
    logic [2:0]  f3s   [0:3];
    logic [8:0]  addrs [0:3];
    exts  = '{1'b0, 1'b0, 1'b1, 1'b1};
    wes   = '{1'b0, 1'b1, 1'b0, 1'b1};
    f3s   = '{3'd2, 3'd1, 3'd3, 3'd4};
    addrs = '{9'h006, 9'h003, 9'h000, 9'h004};
    set_word(0, 32'hCAFE_0000);
    set_word(1, 32'hCAFE_0001);
    for (int i = 0; i < 4; i++) begin
      do_access(exts[i], wes[i], f3s[i], addrs[i], 32'hFFFF_FFFF, lat, rd, er, nwr, stray);
      $display("txn illegal %0d ext=%0d we=%0d f3=%0d addr=%h rdata=%h err=%0d lat=%0d", i, exts[i], wes[i], f3s[i], addrs[i], rd, er, lat);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL illegal_err idx=%0d got=%0d/%h exp=1/0", i, er, rd); end
      checks++; if (lat != 1 || nwr != 0) begin failures++; $display("FAIL illegal_lat_writes idx=%0d got=%0d/%0d exp=1/0", i, lat, nwr); end
      checks++; if (stray !== 1'b0) begin failures++; $display("FAIL illegal_stray idx=%0d got=1 exp=0", i); end
    end
    checks++; if (mem[0] !== 32'hCAFE_0000 || mem[1] !== 32'hCAFE_0001) begin failures++; $display("FAIL illegal_mem got=%h/%h exp=cafe0000/cafe0001", mem[0], mem[1]); end
  endtask

  task automatic test_reset_in_wr();
    int snap, t;
    bit got;
    set_word(12, 32'h0102_0304);
    @(posedge clk); #1;
    core_req = 1; core_we = 1; core_f3 = 3'd0; core_addr = 9'h031; core_wdata = 32'hEE;
    got = 0; t = 0;
    while (!got && t < 16) begin @(negedge clk); t++; if (core_gnt === 1'b1) got = 1; end
    checks++; if (!got) begin failures++; $display("FAIL rstwr_gnt got=timeout exp=grant"); end
    snap = wr_count;
    @(posedge clk); #1 core_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    core_req = 1; core_we = 0; core_f3 = 3'd2; core_addr = 9'h030;
    @(negedge clk);
    checks++; if (mem_wr !== 4'h0) begin failures++; $display("FAIL rstwr_mem_wr got=%h exp=0", mem_wr); end
    checks++; if (core_rvalid !== 1'b0) begin failures++; $display("FAIL rstwr_rvalid_in_reset got=1 exp=0"); end
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    checks++; if (core_gnt !== 1'b1) begin failures++; $display("FAIL rstwr_regrant got=%b exp=1", core_gnt); end
    checks++; if (core_rvalid !== 1'b0) begin failures++; $display("FAIL rstwr_rvalid_after got=1 exp=0"); end
    @(posedge clk); #1 core_req = 0;
    got = 0; t = 1;
    while (!got && t < 10) begin
      @(negedge clk); t++;
      if (core_rvalid === 1'b1) begin
        got = 1;
        checks++; if (core_rdata !== 32'h0102_0304) begin failures++; $display("FAIL rstwr_lw_rdata got=%h exp=01020304", core_rdata); end
      end
    end
    $display("txn reset_during_wr followup_lw lat=%0d", got ? t - 1 : -1);
    checks++; if (!got || t - 1 != 2) begin failures++; $display("FAIL rstwr_lw_latency got=%0d exp=2", got ? t - 1 : -1); end
    checks++; if (wr_count != snap || mem[12] !== 32'h0102_0304) begin failures++; $display("FAIL rstwr_no_write got=%0d/%h exp=0/01020304", wr_count - snap, mem[12]); end
  endtask

  task automatic test_random();
    int lat, nwr, elat, enwr;
    logic [31:0] rd, erd, wd;
    logic [8:0]  addr;
    logic [2:0]  f3;
    bit er, eer, stray, ext, we;
    for (int i = 0; i < 80; i++) begin
      ext  = 1'($urandom % 2);
      we   = 1'($urandom % 2);
      f3   = 3'($urandom_range(0, 7));
      addr = 9'($urandom_range(0, 511));
      if ($urandom % 2 == 0) addr[1:0] = 2'b00;
      wd   = $urandom;
      ref_exec(we, f3, addr, wd, erd, eer, elat, enwr);
      do_access(ext, we, f3, addr, wd, lat, rd, er, nwr, stray);
      $display("txn rand %0d ext=%0d we=%0d f3=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d", i, ext, we, f3, addr, wd, rd, er, lat);
      checks++; if (rd !== erd) begin failures++; $display("FAIL rand_rdata idx=%0d got=%h exp=%h", i, rd, erd); end
      checks++; if (er !== eer) begin failures++; $display("FAIL rand_err idx=%0d got=%0d exp=%0d", i, er, eer); end
      checks++; if (lat != elat) begin failures++; $display("FAIL rand_latency idx=%0d got=%0d exp=%0d", i, lat, elat); end
      checks++; if (nwr != enwr || stray !== 1'b0) begin failures++; $display("FAIL rand_writes_stray idx=%0d got=%0d/%0d exp=%0d/0", i, nwr, stray, enwr); end
    end
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      checks++; if (mem[i] !== ref_mem[i]) begin failures++; $display("FAIL rand_mem word=%0d got=%h exp=%h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    test_reset();
    test_arbitration();
    test_loads();
    test_sub_store();
    test_illegal();
    test_reset_in_wr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
